// File: rtl/mdc_commutator.sv
// rtl/mdc_commutator.sv - MDC radix-2 FFT delay-commutator stage
module mdc_commutator #(
  parameter int NBITS      = 10,
  parameter int DEPTH      = 32,
  parameter int LOG2_DEPTH = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [2*NBITS-1:0]   in_up,
  input  logic [2*NBITS-1:0]   in_down,
  output logic                 out_valid,
  output logic [2*NBITS-1:0]   out_up,
  output logic [2*NBITS-1:0]   out_down
);

  localparam int W = 2 * NBITS;
  localparam logic [LOG2_DEPTH:0] PRIME_FULL = (LOG2_DEPTH + 1)'(DEPTH);

  logic [W-1:0]        dly_a [DEPTH];
  logic [W-1:0]        dly_x [DEPTH];
  logic [LOG2_DEPTH:0] cnt;
  logic [LOG2_DEPTH:0] prime;
  logic                sel;
  logic [W-1:0]        d_a;
  logic [W-1:0]        o_up;
  logic [W-1:0]        o_x;

  assign sel = cnt[LOG2_DEPTH];
  assign d_a = dly_a[DEPTH-1];

  always_comb begin
    o_up = d_a;
    o_x  = in_down;
    if (sel) begin
      o_up = in_down;
      o_x  = d_a;
    end
  end

  // Delay lines hold stale data across reset; prime gates their visibility.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      dly_a[0] <= in_up;
      dly_x[0] <= o_x;
      for (int i = 1; i < DEPTH; i++) begin
        dly_a[i] <= dly_a[i-1];
        dly_x[i] <= dly_x[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      prime     <= '0;
      out_valid <= 1'b0;
      out_up    <= '0;
      out_down  <= '0;
    end else begin
      out_valid <= in_valid && (prime == PRIME_FULL);
      if (in_valid) begin
        cnt      <= cnt + 1'b1;
        out_up   <= o_up;
        out_down <= dly_x[DEPTH-1];
        if (prime != PRIME_FULL) begin
          prime <= prime + 1'b1;
        end
      end
    end
  end

endmodule
